dual_sram: RTL and testbench
============================

DUAL_SRAM -- requirements
Module: dual_sram

Interface
REQ-001 SHALL have parameter Data_Width, default 8: bits per memory word.
REQ-002 SHALL have parameter Addr_Width, default 4: word-address width.
REQ-003 SHALL have parameter Ram_Depth, default 1 << Addr_Width: number of words.
REQ-004 SHALL have parameter Para_Deg, default 2: words transferred per access (parallel degree).
REQ-005 SHALL use one clock and a reset that is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-007 SHALL have port Mem_Clear, input, 1: synchronous active-high reset; clears memory.
REQ-008 SHALL have port Chip_Select, input, 1: block enable; low means no write and no read update.
REQ-009 SHALL have port En_Write, input, 1: write enable.
REQ-010 SHALL have port En_Read, input, 1: read enable.
REQ-011 SHALL have port Write_Addr, input, Addr_Width: base word address of the write group.
REQ-012 SHALL have port Read_Addr, input, Addr_Width: base word address of the read group.
REQ-013 SHALL have port Write_Data, input, Para_Deg*Data_Width: slice k ([k*Data_Width +: Data_Width]) is word k of the group.
REQ-014 SHALL have port Read_Data, output, Para_Deg*Data_Width: registered read group, same slice packing.

Function
REQ-015 SHALL store Ram_Depth words of Data_Width bits; separate write and read ports, usable in the same cycle.
REQ-016 Write: on rising edge with Mem_Clear=0, Chip_Select=1, En_Write=1, mem[(Write_Addr+k) mod Ram_Depth] <= Write_Data slice k, for k = 0..Para_Deg-1.
REQ-017 Read: on rising edge with Mem_Clear=0, Chip_Select=1, En_Read=1, Read_Data slice k <= mem[(Read_Addr+k) mod Ram_Depth]; latency one clock.
REQ-018 Read_Addr and Write_Addr SHALL be arbitrary (unaligned); only the base need not be a multiple of Para_Deg.
REQ-019 Address wrap-around: base+k beyond Ram_Depth-1 SHALL wrap modulo Ram_Depth (Addr_Width-bit truncation when Ram_Depth = 2^Addr_Width).
REQ-020 Read_Data SHALL hold its value when Chip_Select=0 or En_Read=0.
REQ-021 Memory SHALL be unchanged when Chip_Select=0 or En_Write=0.
REQ-022 Simultaneous read and write of an overlapping word SHALL return the old (pre-write) contents (read-before-write).
REQ-023 Read-modify of the full group is atomic: all Para_Deg words update on the same edge.

Reset
REQ-024 Mem_Clear=1 at a rising edge SHALL set every memory word to 0 and Read_Data to 0, regardless of other inputs.
REQ-025 Mem_Clear SHALL take priority over writes and reads in the same cycle; a mid-operation clear discards the in-flight write.
REQ-026 Before the first Mem_Clear, memory and Read_Data contents are undefined.

Structure
REQ-027 A shared package dual_sram_pkg SHALL hold the default width/depth/parallel-degree constants; no typedefs required.
REQ-028 Single flat module; no sub-module. The memory is a word array with generate/for loops over Para_Deg.

Verification (Data_Width=8, Addr_Width=4, Para_Deg=2)
REQ-029 Clear then read address 0 -> Read_Data = 0 one cycle later.
REQ-030 Write {words 1,2} at address 0, {3,4} at address 2, ... through address 14 (words 1..16), then read address 0 -> Read_Data slices {1,2}; read address 1 -> {2,3}.
REQ-031 Read address 15 after REQ-030 load -> slices {16,1} (wrap-around).
REQ-032 Same-cycle write {0xAA,0xBB} at address 4 and read at address 4 -> Read_Data {5,6} (old); next read -> {0xAA,0xBB}.
REQ-033 Chip_Select=0 with En_Write=1 writing {9,9} at address 0 -> memory unchanged; Read_Data holds previous value.
REQ-034 Mem_Clear asserted together with a write -> all words read back as 0.

Source files
------------

// File: rtl/dual_sram_pkg.sv
// Default geometry for the dual-port, multi-word-per-access SRAM.
package dual_sram_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int PARA_DEG_DEF   = 2;
endpackage

// File: rtl/dual_sram.sv
// Dual-port word SRAM moving Para_Deg consecutive words per access at an
// arbitrary base address, with wrap-around and a registered read group.
module dual_sram
    import dual_sram_pkg::*;
#(
    parameter int Data_Width = DATA_WIDTH_DEF,
    parameter int Addr_Width = ADDR_WIDTH_DEF,
    parameter int Ram_Depth  = 1 << Addr_Width,
    parameter int Para_Deg   = PARA_DEG_DEF
) (
    input  logic                         clk,
    input  logic                         Mem_Clear,
    input  logic                         Chip_Select,
    input  logic                         En_Write,
    input  logic                         En_Read,
    input  logic [Addr_Width-1:0]        Write_Addr,
    input  logic [Addr_Width-1:0]        Read_Addr,
    input  logic [Para_Deg*Data_Width-1:0] Write_Data,
    output logic [Para_Deg*Data_Width-1:0] Read_Data
);

    // Word index of base+k folded back into the array, for any depth.
    function automatic logic [Addr_Width-1:0] wrap_addr(input logic [Addr_Width-1:0] base,
                                                        input int unsigned k);
        int unsigned sum;
        sum = int'(base) + k;
        return Addr_Width'(sum % Ram_Depth);
    endfunction

    logic [Data_Width-1:0]         mem_q [Ram_Depth];
    logic [Para_Deg*Data_Width-1:0] rd_q, rd_d;
    logic [Addr_Width-1:0]         waddr [Para_Deg];
    logic [Addr_Width-1:0]         raddr [Para_Deg];

    logic wr_en, rd_en;
    assign wr_en = Chip_Select && En_Write;
    assign rd_en = Chip_Select && En_Read;

    for (genvar k = 0; k < Para_Deg; k++) begin : g_lane
        assign waddr[k] = wrap_addr(Write_Addr, k);
        assign raddr[k] = wrap_addr(Read_Addr, k);
    end

    // Read group samples the pre-edge array, so overlapping writes read old data.
    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            for (int k = 0; k < Para_Deg; k++) begin
                rd_d[k*Data_Width +: Data_Width] = mem_q[raddr[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Mem_Clear) begin
            for (int i = 0; i < Ram_Depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
            if (wr_en) begin
                for (int k = 0; k < Para_Deg; k++) begin
                    mem_q[waddr[k]] <= Write_Data[k*Data_Width +: Data_Width];
                end
            end
        end
    end

    assign Read_Data = rd_q;

endmodule

// File: tb/tb_dual_sram.sv
// Randomized bench for dual_sram with a word-array reference model and pinned cases.
module tb_dual_sram;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int PD = 2;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               Mem_Clear = 1'b0;
    logic               Chip_Select = 1'b0;
    logic               En_Write = 1'b0;
    logic               En_Read = 1'b0;
    logic [AW-1:0]      Write_Addr = '0;
    logic [AW-1:0]      Read_Addr = '0;
    logic [PD*DW-1:0]   Write_Data = '0;
    logic [PD*DW-1:0]   Read_Data;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0]    m_mem [DEPTH];
    logic [PD*DW-1:0] m_rd;
    bit               model_valid = 1'b0;

    dual_sram #(.Data_Width(DW), .Addr_Width(AW), .Ram_Depth(DEPTH), .Para_Deg(PD)) dut (
        .clk(clk), .Mem_Clear(Mem_Clear), .Chip_Select(Chip_Select),
        .En_Write(En_Write), .En_Read(En_Read), .Write_Addr(Write_Addr),
        .Read_Addr(Read_Addr), .Write_Data(Write_Data), .Read_Data(Read_Data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PD*DW-1:0] act, input logic [PD*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a group read sees the array as it was before this edge's write.
    task automatic model_edge();
        logic [PD*DW-1:0] grp;
        if (Mem_Clear) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_rd = '0;
            model_valid = 1'b1;
        end else if (Chip_Select) begin
            if (En_Read) begin
                for (int k = 0; k < PD; k++) grp[k*DW +: DW] = m_mem[(int'(Read_Addr) + k) % DEPTH];
                m_rd = grp;
            end
            if (En_Write) begin
                for (int k = 0; k < PD; k++) m_mem[(int'(Write_Addr) + k) % DEPTH] = Write_Data[k*DW +: DW];
            end
        end
    endtask

    task automatic step(input bit clr, input bit cs, input bit we, input bit re,
                        input int wa, input int ra, input logic [PD*DW-1:0] wd);
        Mem_Clear = clr; Chip_Select = cs; En_Write = we; En_Read = re;
        Write_Addr = AW'(wa); Read_Addr = AW'(ra); Write_Data = wd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (model_valid) check("model_rd", Read_Data, m_rd);
    end

    initial begin
        @(negedge clk);
        // Clear together with a write; nothing may land in memory.
        step(1, 1, 1, 1, 0, 0, 16'h0909);
        check("clear_rd_zero", Read_Data, 16'h0000);
        step(0, 1, 0, 1, 0, 0, 16'h0);
        check("read0_after_clear", Read_Data, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            logic [7:0] lo, hi;
            lo = 8'(2*i + 1);
            hi = 8'(2*i + 2);
            step(0, 1, 1, 0, 2*i, 0, {hi, lo});
        end
        step(0, 1, 0, 1, 0, 0, 16'h0);
        check("read_addr0", Read_Data, 16'h0201);
        step(0, 1, 0, 1, 0, 1, 16'h0);
        check("read_addr1_unaligned", Read_Data, 16'h0302);
        step(0, 1, 0, 1, 0, 15, 16'h0);
        check("read_addr15_wrap", Read_Data, 16'h0110);

        step(0, 1, 1, 1, 4, 4, 16'hBBAA);
        check("rbw_old_data", Read_Data, 16'h0605);
        step(0, 1, 0, 1, 0, 4, 16'h0);
        check("rbw_new_data", Read_Data, 16'hBBAA);

        step(0, 0, 1, 1, 0, 0, 16'h0909);
        check("cs_low_hold", Read_Data, 16'hBBAA);
        step(0, 1, 0, 0, 0, 7, 16'h0);
        check("en_read_low_hold", Read_Data, 16'hBBAA);
        step(0, 1, 0, 1, 0, 0, 16'h0);
        check("cs_low_no_write", Read_Data, 16'h0201);

        step(0, 1, 1, 0, 15, 0, 16'h5A3C);
        step(0, 1, 0, 1, 0, 15, 16'h0);
        check("write_wrap_15_0", Read_Data, 16'h5A3C);

        step(1, 1, 1, 1, 0, 0, 16'hFFFF);
        for (int a = 0; a < DEPTH; a++) begin
            step(0, 1, 0, 1, 0, a, 16'h0);
            check("cleared_word", Read_Data, 16'h0000);
        end

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
                 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
